// File: rtl/instr_encoder.sv
// Field-level request to 32-bit MIPS word encoder that streams each encoded word
// into instruction memory at consecutive addresses through a one-entry output register.
module instr_encoder #(
    parameter int          ADDR_W    = 8,
    parameter int unsigned BASE_ADDR = 0
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic              finish,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [2:0]        in_kind,
    input  logic [4:0]        in_rs,
    input  logic [4:0]        in_rt,
    input  logic [4:0]        in_rd,
    input  logic [4:0]        in_shamt,
    input  logic [5:0]        in_funct,
    input  logic [15:0]       in_imm,
    input  logic [25:0]       in_target,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [ADDR_W-1:0] out_addr,
    output logic [31:0]       out_instr,
    output logic [ADDR_W:0]   words,
    output logic              busy,
    output logic              done,
    output logic              err_illegal,
    output logic              err_full
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_RUN   = 2'd1,
        S_FULL  = 2'd2,
        S_DRAIN = 2'd3
    } state_t;

    localparam logic [ADDR_W-1:0] BASE_A = ADDR_W'(BASE_ADDR);
    localparam logic [ADDR_W-1:0] LAST_A = {ADDR_W{1'b1}};

    function automatic logic [31:0] encode(
        input logic [2:0]  kind,
        input logic [4:0]  rs,
        input logic [4:0]  rt,
        input logic [4:0]  rd,
        input logic [4:0]  shamt,
        input logic [5:0]  funct,
        input logic [15:0] imm,
        input logic [25:0] target
    );
        logic [31:0] w;
        case (kind)
            3'd0:    w = {6'b000000, rs, rt, rd, shamt, funct};
            3'd1:    w = {6'b100011, rs, rt, imm};
            3'd2:    w = {6'b101011, rs, rt, imm};
            3'd3:    w = {6'b000101, rs, rt, imm};
            3'd4:    w = {6'b001110, rs, rt, imm};
            3'd5:    w = {6'b000010, target};
            default: w = 32'h0000_0000;
        endcase
        return w;
    endfunction

    state_t              state_q, state_d;
    logic                out_valid_q, out_valid_d;
    logic [ADDR_W-1:0]   out_addr_q, out_addr_d;
    logic [31:0]         out_instr_q, out_instr_d;
    logic [ADDR_W:0]     words_q, words_d;
    logic                done_q, done_d;
    logic                err_illegal_q, err_illegal_d;
    logic                err_full_q, err_full_d;
    logic                in_ready_s, accept_s, write_s, legal_s, last_pending_s;

    // Handshake decode and next-state / datapath update.
    always_comb begin
        state_d       = state_q;
        out_valid_d   = out_valid_q;
        out_addr_d    = out_addr_q;
        out_instr_d   = out_instr_q;
        words_d       = words_q;
        done_d        = 1'b0;
        err_illegal_d = err_illegal_q;
        err_full_d    = err_full_q;

        // A word pending at the last address must not be followed: memory is full after it.
        last_pending_s = out_valid_q && (out_addr_q == LAST_A);
        in_ready_s     = (state_q == S_RUN) && (!out_valid_q || out_ready) && !last_pending_s;
        accept_s       = in_valid && in_ready_s;
        write_s        = out_valid_q && out_ready;
        legal_s        = (in_kind <= 3'd5);

        if (write_s) begin
            out_addr_d  = out_addr_q + ADDR_W'(1);
            words_d     = words_q + (ADDR_W + 1)'(1);
            out_valid_d = 1'b0;
        end else begin
            out_valid_d = out_valid_q;
        end

        if (accept_s && legal_s) begin
            out_instr_d = encode(in_kind, in_rs, in_rt, in_rd, in_shamt, in_funct, in_imm, in_target);
            out_valid_d = 1'b1;
        end else if (accept_s) begin
            err_illegal_d = 1'b1;
        end else begin
            out_instr_d = out_instr_q;
        end

        case (state_q)
            S_IDLE: begin
                if (start) begin
                    state_d       = S_RUN;
                    out_addr_d    = BASE_A;
                    words_d       = '0;
                    err_illegal_d = 1'b0;
                    err_full_d    = 1'b0;
                end else begin
                    state_d = S_IDLE;
                end
            end
            S_RUN: begin
                if (finish) begin
                    state_d = S_DRAIN;
                end else if (write_s && (out_addr_q == LAST_A)) begin
                    state_d = S_FULL;
                end else begin
                    state_d = S_RUN;
                end
            end
            S_FULL: begin
                if (in_valid) begin
                    err_full_d = 1'b1;
                end else begin
                    err_full_d = err_full_q;
                end
                if (finish) begin
                    state_d = S_DRAIN;
                end else begin
                    state_d = S_FULL;
                end
            end
            S_DRAIN: begin
                if (!out_valid_q) begin
                    state_d = S_IDLE;
                    done_d  = 1'b1;
                end else begin
                    state_d = S_DRAIN;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    // State and output registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= S_IDLE;
            out_valid_q   <= 1'b0;
            out_addr_q    <= BASE_A;
            out_instr_q   <= 32'h0000_0000;
            words_q       <= '0;
            done_q        <= 1'b0;
            err_illegal_q <= 1'b0;
            err_full_q    <= 1'b0;
        end else begin
            state_q       <= state_d;
            out_valid_q   <= out_valid_d;
            out_addr_q    <= out_addr_d;
            out_instr_q   <= out_instr_d;
            words_q       <= words_d;
            done_q        <= done_d;
            err_illegal_q <= err_illegal_d;
            err_full_q    <= err_full_d;
        end
    end

    assign in_ready    = in_ready_s;
    assign out_valid   = out_valid_q;
    assign out_addr    = out_addr_q;
    assign out_instr   = out_instr_q;
    assign words       = words_q;
    assign busy        = (state_q != S_IDLE);
    assign done        = done_q;
    assign err_illegal = err_illegal_q;
    assign err_full    = err_full_q;

endmodule

// File: tb/tb_instr_encoder.sv
// Directed bench for instr_encoder: a default-size instance plus an ADDR_W=2 instance for the full case.
module tb_instr_encoder;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        start, finish, start_s, finish_s;
    logic        in_valid, out_ready;
    logic [2:0]  in_kind;
    logic [4:0]  in_rs, in_rt, in_rd, in_shamt;
    logic [5:0]  in_funct;
    logic [15:0] in_imm;
    logic [25:0] in_target;

    logic        in_ready, out_valid, busy, done, err_illegal, err_full;
    logic [7:0]  out_addr;
    logic [31:0] out_instr;
    logic [8:0]  words;

    logic        in_ready_s, out_valid_s, busy_s, done_s, err_illegal_s, err_full_s;
    logic [1:0]  out_addr_s;
    logic [31:0] out_instr_s;
    logic [2:0]  words_s;

    int n_vec = 0;
    int n_bad = 0;
    logic [39:0] exp_q[$];
    logic [39:0] exp_s_q[$];

    always #5 clk = ~clk;

    instr_encoder #(.ADDR_W(8), .BASE_ADDR(0)) u_dut (
        .clk(clk), .rst_n(rst_n), .start(start), .finish(finish),
        .in_valid(in_valid), .in_ready(in_ready), .in_kind(in_kind),
        .in_rs(in_rs), .in_rt(in_rt), .in_rd(in_rd), .in_shamt(in_shamt),
        .in_funct(in_funct), .in_imm(in_imm), .in_target(in_target),
        .out_valid(out_valid), .out_ready(out_ready), .out_addr(out_addr),
        .out_instr(out_instr), .words(words), .busy(busy), .done(done),
        .err_illegal(err_illegal), .err_full(err_full)
    );

    instr_encoder #(.ADDR_W(2), .BASE_ADDR(0)) u_dut_s (
        .clk(clk), .rst_n(rst_n), .start(start_s), .finish(finish_s),
        .in_valid(in_valid), .in_ready(in_ready_s), .in_kind(in_kind),
        .in_rs(in_rs), .in_rt(in_rt), .in_rd(in_rd), .in_shamt(in_shamt),
        .in_funct(in_funct), .in_imm(in_imm), .in_target(in_target),
        .out_valid(out_valid_s), .out_ready(out_ready), .out_addr(out_addr_s),
        .out_instr(out_instr_s), .words(words_s), .busy(busy_s), .done(done_s),
        .err_illegal(err_illegal_s), .err_full(err_full_s)
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Memory-side scoreboards: every completed write must match the next expected word.
    always @(negedge clk) begin
        if (rst_n && out_valid && out_ready) begin
            if (exp_q.size() == 0) begin
                chk("wr_unexpected", 64'd1, 64'd0);
            end else begin
                logic [39:0] e;
                e = exp_q.pop_front();
                chk("wr_addr", {56'd0, out_addr}, {56'd0, e[39:32]});
                chk("wr_instr", {32'd0, out_instr}, {32'd0, e[31:0]});
            end
        end
        if (rst_n && out_valid_s && out_ready) begin
            if (exp_s_q.size() == 0) begin
                chk("s_wr_unexpected", 64'd1, 64'd0);
            end else begin
                logic [39:0] e;
                e = exp_s_q.pop_front();
                chk("s_wr_addr", {62'd0, out_addr_s}, {56'd0, e[39:32]});
                chk("s_wr_instr", {32'd0, out_instr_s}, {32'd0, e[31:0]});
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic pulse_start(input bit sel);
        if (sel) start_s = 1'b1; else start = 1'b1;
        step();
        start = 1'b0; start_s = 1'b0;
    endtask

    task automatic pulse_finish(input bit sel);
        if (sel) finish_s = 1'b1; else finish = 1'b1;
        step();
        finish = 1'b0; finish_s = 1'b0;
    endtask

    task automatic send(input bit sel, input logic [2:0] k, input logic [4:0] rs, input logic [4:0] rt,
                        input logic [4:0] rd, input logic [4:0] sh, input logic [5:0] fn,
                        input logic [15:0] imm, input logic [25:0] tgt);
        int n;
        in_kind = k; in_rs = rs; in_rt = rt; in_rd = rd; in_shamt = sh;
        in_funct = fn; in_imm = imm; in_target = tgt;
        in_valid = 1'b1;
        n = 0;
        @(negedge clk);
        while (!(sel ? in_ready_s : in_ready) && n < 50) begin
            @(negedge clk);
            n++;
        end
        chk("accept", {63'd0, (sel ? in_ready_s : in_ready)}, 64'd1);
        step();
        in_valid = 1'b0;
    endtask

    task automatic wait_done(input bit sel);
        int  n;
        bit  seen;
        n = 0; seen = 1'b0;
        while (n < 30 && !seen) begin
            @(negedge clk);
            seen = sel ? done_s : done;
            n++;
        end
        chk("done_pulse", {63'd0, seen}, 64'd1);
        chk("idle_after_done", {63'd0, (sel ? busy_s : busy)}, 64'd0);
        step();
    endtask

    task automatic expect_wr(input bit sel, input logic [7:0] a, input logic [31:0] w);
        if (sel) exp_s_q.push_back({a, w}); else exp_q.push_back({a, w});
    endtask

    initial begin
        rst_n = 1'b0; start = 1'b0; finish = 1'b0; start_s = 1'b0; finish_s = 1'b0;
        in_valid = 1'b0; out_ready = 1'b1; in_kind = 3'd0;
        in_rs = 5'd0; in_rt = 5'd0; in_rd = 5'd0; in_shamt = 5'd0;
        in_funct = 6'd0; in_imm = 16'd0; in_target = 26'd0;

        repeat (2) @(negedge clk);
        chk("rst_in_ready", {63'd0, in_ready}, 64'd0);
        chk("rst_out_valid", {63'd0, out_valid}, 64'd0);
        chk("rst_done", {63'd0, done}, 64'd0);
        chk("rst_errs", {62'd0, err_illegal, err_full}, 64'd0);
        chk("rst_addr", {56'd0, out_addr}, 64'd0);
        chk("rst_instr", {32'd0, out_instr}, 64'd0);
        chk("rst_words", {55'd0, words}, 64'd0);
        chk("rst_busy", {63'd0, busy}, 64'd0);
        step();
        rst_n = 1'b1;
        step();

        // finish while IDLE is ignored
        pulse_finish(1'b0);
        @(negedge clk);
        chk("idle_finish_ignored", {63'd0, busy}, 64'd0);
        step();

        // Program A: single R-type word
        pulse_start(1'b0);
        @(negedge clk);
        chk("start_busy", {63'd0, busy}, 64'd1);
        chk("start_addr", {56'd0, out_addr}, 64'd0);
        chk("start_in_ready", {63'd0, in_ready}, 64'd1);
        step();
        expect_wr(1'b0, 8'd0, 32'h0022_1820);
        send(1'b0, 3'd0, 5'd1, 5'd2, 5'd3, 5'd0, 6'h20, 16'h0000, 26'h0);
        repeat (2) step();
        chk("a_words", {55'd0, words}, 64'd1);
        pulse_finish(1'b0);
        wait_done(1'b0);

        // Program B: I-type and jump encodings, then an out_ready stall
        pulse_start(1'b0);
        expect_wr(1'b0, 8'd0, 32'h8FA8_0004);
        expect_wr(1'b0, 8'd1, 32'h1422_FFFD);
        expect_wr(1'b0, 8'd2, 32'h3822_FFFF);
        expect_wr(1'b0, 8'd3, 32'h0800_0010);
        send(1'b0, 3'd1, 5'd29, 5'd8, 5'd0, 5'd0, 6'd0, 16'h0004, 26'h0);
        send(1'b0, 3'd3, 5'd1, 5'd2, 5'd0, 5'd0, 6'd0, 16'hFFFD, 26'h0);
        send(1'b0, 3'd4, 5'd1, 5'd2, 5'd0, 5'd0, 6'd0, 16'hFFFF, 26'h0);
        send(1'b0, 3'd5, 5'd0, 5'd0, 5'd0, 5'd0, 6'd0, 16'h0000, 26'h10);
        repeat (2) step();
        chk("b_words", {55'd0, words}, 64'd4);

        expect_wr(1'b0, 8'd4, 32'h0085_3080);
        expect_wr(1'b0, 8'd5, 32'h3863_00FF);
        out_ready = 1'b0;
        in_kind = 3'd0; in_rs = 5'd4; in_rt = 5'd5; in_rd = 5'd6; in_shamt = 5'd2; in_funct = 6'd0;
        in_valid = 1'b1;
        step();
        in_kind = 3'd4; in_rs = 5'd3; in_rt = 5'd3; in_imm = 16'h00FF;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            chk("stall_in_ready", {63'd0, in_ready}, 64'd0);
            chk("stall_valid", {63'd0, out_valid}, 64'd1);
            chk("stall_instr", {32'd0, out_instr}, {32'd0, 32'h0085_3080});
            chk("stall_addr", {56'd0, out_addr}, 64'd4);
            step();
        end
        out_ready = 1'b1;
        @(negedge clk);
        chk("release_in_ready", {63'd0, in_ready}, 64'd1);
        step();
        in_valid = 1'b0;
        @(negedge clk);
        chk("b2b_valid", {63'd0, out_valid}, 64'd1);
        step();
        repeat (2) step();
        chk("b_words_final", {55'd0, words}, 64'd6);
        pulse_finish(1'b0);
        wait_done(1'b0);

        // Program C: illegal kind between two legal ops
        pulse_start(1'b0);
        chk("c_err_cleared", {63'd0, err_illegal}, 64'd0);
        expect_wr(1'b0, 8'd0, 32'h0022_1820);
        expect_wr(1'b0, 8'd1, 32'h0800_0010);
        send(1'b0, 3'd0, 5'd1, 5'd2, 5'd3, 5'd0, 6'h20, 16'h0000, 26'h0);
        send(1'b0, 3'd6, 5'd7, 5'd7, 5'd7, 5'd7, 6'h3F, 16'h1234, 26'h0);
        send(1'b0, 3'd5, 5'd0, 5'd0, 5'd0, 5'd0, 6'd0, 16'h0000, 26'h10);
        repeat (2) step();
        chk("c_err_illegal", {63'd0, err_illegal}, 64'd1);
        chk("c_words", {55'd0, words}, 64'd2);
        pulse_finish(1'b0);
        wait_done(1'b0);

        // Small instance: four writes fill memory, fifth request flags err_full
        pulse_start(1'b1);
        expect_wr(1'b1, 8'd0, 32'h8FA8_0004);
        expect_wr(1'b1, 8'd1, 32'h1422_FFFD);
        expect_wr(1'b1, 8'd2, 32'h3822_FFFF);
        expect_wr(1'b1, 8'd3, 32'h0800_0010);
        send(1'b1, 3'd1, 5'd29, 5'd8, 5'd0, 5'd0, 6'd0, 16'h0004, 26'h0);
        send(1'b1, 3'd3, 5'd1, 5'd2, 5'd0, 5'd0, 6'd0, 16'hFFFD, 26'h0);
        send(1'b1, 3'd4, 5'd1, 5'd2, 5'd0, 5'd0, 6'd0, 16'hFFFF, 26'h0);
        send(1'b1, 3'd5, 5'd0, 5'd0, 5'd0, 5'd0, 6'd0, 16'h0000, 26'h10);
        in_kind = 3'd0; in_valid = 1'b1;
        repeat (4) step();
        @(negedge clk);
        chk("s_in_ready", {63'd0, in_ready_s}, 64'd0);
        chk("s_err_full", {63'd0, err_full_s}, 64'd1);
        chk("s_words", {61'd0, words_s}, 64'd4);
        chk("s_out_valid", {63'd0, out_valid_s}, 64'd0);
        chk("s_busy", {63'd0, busy_s}, 64'd1);
        step();
        in_valid = 1'b0;
        pulse_finish(1'b1);
        wait_done(1'b1);

        // Program E: reset while a word is stalled
        pulse_start(1'b0);
        expect_wr(1'b0, 8'd0, 32'h0800_0010);
        send(1'b0, 3'd5, 5'd0, 5'd0, 5'd0, 5'd0, 6'd0, 16'h0000, 26'h10);
        repeat (2) step();
        out_ready = 1'b0;
        send(1'b0, 3'd0, 5'd1, 5'd2, 5'd3, 5'd0, 6'h20, 16'h0000, 26'h0);
        @(negedge clk);
        chk("e_pending", {63'd0, out_valid}, 64'd1);
        chk("e_words_pre", {55'd0, words}, 64'd1);
        rst_n = 1'b0;
        #1;
        chk("e_rst_valid", {63'd0, out_valid}, 64'd0);
        chk("e_rst_words", {55'd0, words}, 64'd0);
        chk("e_rst_busy", {63'd0, busy}, 64'd0);
        chk("e_rst_addr", {56'd0, out_addr}, 64'd0);
        step();
        rst_n = 1'b1;
        out_ready = 1'b1;
        step();
        pulse_start(1'b0);
        expect_wr(1'b0, 8'd0, 32'h8FA8_0004);
        send(1'b0, 3'd1, 5'd29, 5'd8, 5'd0, 5'd0, 6'd0, 16'h0004, 26'h0);
        repeat (2) step();
        chk("e_words_after", {55'd0, words}, 64'd1);
        pulse_finish(1'b0);
        wait_done(1'b0);

        chk("sb_empty", {32'd0, exp_q.size()}, 64'd0);
        chk("sb_s_empty", {32'd0, exp_s_q.size()}, 64'd0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
